// File: rtl/fifo2nfifo_pkg.sv
// Shared widths and helpers for the single-writer, multi-flow FIFO.
package fifo2nfifo_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_FLOWS      = 2;
  localparam int DEF_BLOCK_SIZE = 16;

  // Smallest r with 2**r >= value.
  function automatic int log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Head/tail pointer width inside one flow buffer.
  function automatic int ptr_width(input int block_size);
    return log2(block_size);
  endfunction

  // Occupancy counter width; one extra bit so a full buffer is representable.
  function automatic int count_width(input int block_size);
    return log2(block_size) + 1;
  endfunction

  // Flow index width; never narrower than one bit.
  function automatic int flow_width(input int flows);
    return (flows > 1) ? log2(flows) : 1;
  endfunction

endpackage

// File: rtl/fifo2nfifo_if.sv
// Producer/consumer bundle of the multi-flow FIFO: one write channel, FLOWS read ports.
interface fifo2nfifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int FLOWS      = 2,
  parameter int BLOCK_SIZE = 16
);
  import fifo2nfifo_pkg::*;

  localparam int WORD_W  = DATA_WIDTH / FLOWS;
  localparam int FLOW_W  = flow_width(FLOWS);
  localparam int COUNT_W = count_width(BLOCK_SIZE);

  logic [WORD_W-1:0]        DATA_IN;
  logic [FLOW_W-1:0]        BLOCK_ADDR;
  logic                     WRITE;
  logic [FLOWS-1:0]         FULL;
  logic [DATA_WIDTH-1:0]    DATA_OUT;
  logic [FLOWS-1:0]         DATA_VLD;
  logic [FLOWS-1:0]         READ;
  logic [FLOWS-1:0]         EMPTY;
  logic [FLOWS*COUNT_W-1:0] STATUS;

  modport master (
    output DATA_IN, BLOCK_ADDR, WRITE, READ,
    input  FULL, DATA_OUT, DATA_VLD, EMPTY, STATUS
  );

  modport slave (
    input  DATA_IN, BLOCK_ADDR, WRITE, READ,
    output FULL, DATA_OUT, DATA_VLD, EMPTY, STATUS
  );

endinterface

// File: rtl/fifo2nfifo_mem.sv
// Shared storage for all flow buffers: one write port, one asynchronous read port per flow.
module fifo2nfifo_mem import fifo2nfifo_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int FLOWS      = 2,
  parameter int BLOCK_SIZE = 16,
  parameter int LUT_MEMORY = 1,
  parameter int ADDR_W     = 5
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [FLOWS*ADDR_W-1:0] raddr,
  output logic [FLOWS*WIDTH-1:0]  rdata
);

  localparam int DEPTH = FLOWS * BLOCK_SIZE;

  generate
    if (LUT_MEMORY != 0) begin : g_lut
      logic [WIDTH-1:0] ram [DEPTH];

      // Distributed RAM: addressed write, contents deliberately never reset
      always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
      end

      for (genvar f = 0; f < FLOWS; f++) begin : g_rd
        assign rdata[f*WIDTH +: WIDTH] = ram[raddr[f*ADDR_W +: ADDR_W]];
      end
    end else begin : g_ff
      logic [WIDTH-1:0] regs [DEPTH];

      // Flip-flop array: only the addressed word loads, contents never reset
      always_ff @(posedge clk) begin
        for (int w = 0; w < DEPTH; w++) begin
          if (we && (waddr == ADDR_W'(w))) regs[w] <= wdata;
        end
      end

      for (genvar f = 0; f < FLOWS; f++) begin : g_rd
        assign rdata[f*WIDTH +: WIDTH] = regs[raddr[f*ADDR_W +: ADDR_W]];
      end
    end
  endgenerate

endmodule

// File: rtl/fifo2nfifo.sv
// Demultiplexes one tagged write stream into FLOWS private circular buffers,
// each with its own read port, registered flags and occupancy count.
module fifo2nfifo import fifo2nfifo_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int FLOWS      = 2,
  parameter int BLOCK_SIZE = 16,
  parameter int LUT_MEMORY = 1,
  parameter int GLOB_STATE = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  fifo2nfifo_if.slave bus
);

  localparam int WORD_W  = DATA_WIDTH / FLOWS;
  localparam int FLOW_W  = flow_width(FLOWS);
  localparam int PTR_W   = ptr_width(BLOCK_SIZE);
  localparam int COUNT_W = count_width(BLOCK_SIZE);
  localparam int ADDR_W  = FLOW_W + PTR_W;
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(BLOCK_SIZE);

  logic [PTR_W-1:0]         tail_vec [FLOWS];
  logic [FLOWS*ADDR_W-1:0]  rd_addr;
  logic [FLOWS*WORD_W-1:0]  rd_data;
  logic [ADDR_W-1:0]        wr_addr;
  logic                     mem_we;
  logic [FLOWS-1:0]         wr_acc;
  logic [FLOWS-1:0]         rd_acc;
  logic [FLOWS-1:0]         full_flow;
  logic [FLOWS-1:0]         empty_flag;
  logic [FLOWS-1:0]         vld_flag;
  logic [DATA_WIDTH-1:0]    data_out;
  logic [FLOWS*COUNT_W-1:0] status;

  // Flow index forms the upper address bits, so each flow owns a BLOCK_SIZE slice.
  assign wr_addr = {bus.BLOCK_ADDR, tail_vec[bus.BLOCK_ADDR]};
  assign mem_we  = |wr_acc;

  fifo2nfifo_mem #(
    .WIDTH      (WORD_W),
    .FLOWS      (FLOWS),
    .BLOCK_SIZE (BLOCK_SIZE),
    .LUT_MEMORY (LUT_MEMORY),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (bus.DATA_IN),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  generate
    for (genvar i = 0; i < FLOWS; i++) begin : g_flow
      logic [PTR_W-1:0]   head;
      logic [PTR_W-1:0]   tail;
      logic [COUNT_W-1:0] count;
      logic [COUNT_W-1:0] count_nxt;
      logic [WORD_W-1:0]  dout;
      logic               full_r;
      logic               empty_r;
      logic               vld_r;

      assign wr_acc[i]  = bus.WRITE && (bus.BLOCK_ADDR == FLOW_W'(i)) && (count != FULL_COUNT);
      assign rd_acc[i]  = bus.READ[i] && (count != '0);
      assign count_nxt  = count + COUNT_W'(wr_acc[i]) - COUNT_W'(rd_acc[i]);
      assign tail_vec[i] = tail;
      assign rd_addr[i*ADDR_W +: ADDR_W] = {FLOW_W'(i), head};

      // Per-flow pointers, count, flags and read register; flags follow the next count
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          head    <= '0;
          tail    <= '0;
          count   <= '0;
          dout    <= '0;
          vld_r   <= 1'b0;
          full_r  <= 1'b0;
          empty_r <= 1'b1;
        end else begin
          if (wr_acc[i]) tail <= tail + PTR_W'(1);
          if (rd_acc[i]) begin
            head <= head + PTR_W'(1);
            dout <= rd_data[i*WORD_W +: WORD_W];
          end
          vld_r   <= rd_acc[i];
          count   <= count_nxt;
          full_r  <= (count_nxt == FULL_COUNT);
          empty_r <= (count_nxt == '0);
        end
      end

      assign data_out[i*WORD_W +: WORD_W]  = dout;
      assign status[i*COUNT_W +: COUNT_W]  = count;
      assign full_flow[i]  = full_r;
      assign empty_flag[i] = empty_r;
      assign vld_flag[i]   = vld_r;
    end
  endgenerate

  // Global mode reports any full flow on every FULL bit; drops still use the own count.
  assign bus.FULL     = (GLOB_STATE != 0) ? {FLOWS{|full_flow}} : full_flow;
  assign bus.EMPTY    = empty_flag;
  assign bus.DATA_VLD = vld_flag;
  assign bus.DATA_OUT = data_out;
  assign bus.STATUS   = status;

endmodule

// File: tb/tb_fifo2nfifo.sv
// Randomised and directed traffic on two instances (per-flow and global FULL),
// checked against per-flow queues by a scoreboard monitor.
module tb_fifo2nfifo;

  localparam int DATA_WIDTH = 64;
  localparam int FLOWS      = 2;
  localparam int BLOCK_SIZE = 16;
  localparam int WORD_W     = 32;
  localparam int COUNT_W    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  logic [WORD_W-1:0] modelQ [FLOWS][$];
  logic [WORD_W-1:0] expQ   [FLOWS][$];
  logic [WORD_W-1:0] lastOut [FLOWS];

  fifo2nfifo_if #(.DATA_WIDTH(DATA_WIDTH), .FLOWS(FLOWS), .BLOCK_SIZE(BLOCK_SIZE)) busA ();
  fifo2nfifo_if #(.DATA_WIDTH(DATA_WIDTH), .FLOWS(FLOWS), .BLOCK_SIZE(BLOCK_SIZE)) busB ();

  fifo2nfifo #(
    .DATA_WIDTH(DATA_WIDTH), .FLOWS(FLOWS), .BLOCK_SIZE(BLOCK_SIZE),
    .LUT_MEMORY(1), .GLOB_STATE(0)
  ) dutA (
    .CLK   (clk),
    .RESET (rst),
    .bus   (busA.slave)
  );

  fifo2nfifo #(
    .DATA_WIDTH(DATA_WIDTH), .FLOWS(FLOWS), .BLOCK_SIZE(BLOCK_SIZE),
    .LUT_MEMORY(0), .GLOB_STATE(1)
  ) dutB (
    .CLK   (clk),
    .RESET (rst),
    .bus   (busB.slave)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Drive both instances identically, then let one rising edge consume the inputs.
  task automatic applyStimulus(input logic wr, input logic addr, input logic [WORD_W-1:0] data,
                               input logic [FLOWS-1:0] rd);
    busA.WRITE = wr; busA.BLOCK_ADDR = addr; busA.DATA_IN = data; busA.READ = rd;
    busB.WRITE = wr; busB.BLOCK_ADDR = addr; busB.DATA_IN = data; busB.READ = rd;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  // Reference model: each flow is a bounded queue; reads see the contents before this edge's write.
  initial begin
    int oldSize [FLOWS];
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < FLOWS; i++) begin
          modelQ[i].delete();
          expQ[i].delete();
        end
      end else begin
        for (int i = 0; i < FLOWS; i++) oldSize[i] = modelQ[i].size();
        for (int i = 0; i < FLOWS; i++) begin
          if (busA.READ[i] && oldSize[i] > 0) expQ[i].push_back(modelQ[i].pop_front());
        end
        if (busA.WRITE && oldSize[busA.BLOCK_ADDR] < BLOCK_SIZE)
          modelQ[busA.BLOCK_ADDR].push_back(busA.DATA_IN);
      end
    end
  end

  // Scoreboard monitor: pops the word due this cycle and compares every output of both instances.
  initial begin
    logic [FLOWS-1:0]         expVld;
    logic [FLOWS-1:0]         expEmpty;
    logic [FLOWS-1:0]         fullFlow;
    logic [FLOWS-1:0]         expFullB;
    logic [FLOWS*COUNT_W-1:0] expStatus;
    logic [DATA_WIDTH-1:0]    expData;
    for (int i = 0; i < FLOWS; i++) lastOut[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < FLOWS; i++) lastOut[i] = '0;
      end
      for (int i = 0; i < FLOWS; i++) begin
        expVld[i] = 1'b0;
        if (expQ[i].size() > 0) begin
          lastOut[i] = expQ[i].pop_front();
          expVld[i]  = 1'b1;
        end
        expEmpty[i] = (modelQ[i].size() == 0);
        fullFlow[i] = (modelQ[i].size() == BLOCK_SIZE);
        expStatus[i*COUNT_W +: COUNT_W] = COUNT_W'(modelQ[i].size());
        expData[i*WORD_W +: WORD_W]     = lastOut[i];
      end
      expFullB = (|fullFlow) ? '1 : '0;

      checkOutput("A.DATA_VLD", 64'(busA.DATA_VLD), 64'(expVld));
      checkOutput("A.DATA_OUT", 64'(busA.DATA_OUT), 64'(expData));
      checkOutput("A.EMPTY",    64'(busA.EMPTY),    64'(expEmpty));
      checkOutput("A.FULL",     64'(busA.FULL),     64'(fullFlow));
      checkOutput("A.STATUS",   64'(busA.STATUS),   64'(expStatus));
      checkOutput("B.DATA_VLD", 64'(busB.DATA_VLD), 64'(expVld));
      checkOutput("B.DATA_OUT", 64'(busB.DATA_OUT), 64'(expData));
      checkOutput("B.EMPTY",    64'(busB.EMPTY),    64'(expEmpty));
      checkOutput("B.FULL",     64'(busB.FULL),     64'(expFullB));
      checkOutput("B.STATUS",   64'(busB.STATUS),   64'(expStatus));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not reach its end, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed scenarios first, then random traffic with changing fill pressure.
  initial begin
    busA.WRITE = 1'b0; busA.BLOCK_ADDR = '0; busA.DATA_IN = '0; busA.READ = '0;
    busB.WRITE = 1'b0; busB.BLOCK_ADDR = '0; busB.DATA_IN = '0; busB.READ = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(3);

    $display("[TB] two words through flow 1");
    applyStimulus(1'b1, 1'b1, 32'hA1, 2'b00);
    applyStimulus(1'b1, 1'b1, 32'hA2, 2'b00);
    applyStimulus(1'b0, 1'b0, '0, 2'b10);
    applyStimulus(1'b0, 1'b0, '0, 2'b10);
    idle(2);

    $display("[TB] overfill flow 0 then drain");
    for (int k = 0; k < 17; k++) applyStimulus(1'b1, 1'b0, 32'(k), 2'b00);
    for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b0, '0, 2'b01);
    idle(2);

    $display("[TB] write and read together on a full flow");
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, 32'h100 + 32'(k), 2'b00);
    applyStimulus(1'b1, 1'b0, 32'h55, 2'b01);
    for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b0, '0, 2'b01);
    idle(2);

    $display("[TB] write and read together on an empty flow");
    applyStimulus(1'b1, 1'b1, 32'h77, 2'b10);
    applyStimulus(1'b0, 1'b0, '0, 2'b10);
    idle(2);

    $display("[TB] global full reporting");
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, 32'h200 + 32'(k), 2'b00);
    applyStimulus(1'b1, 1'b1, 32'h99, 2'b00);
    applyStimulus(1'b0, 1'b0, '0, 2'b01);
    idle(1);
    for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b0, '0, 2'b11);
    idle(2);

    $display("[TB] asynchronous reset during traffic");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'(k), 32'h300 + 32'(k), 2'b00);
    busA.WRITE = 1'b1; busA.BLOCK_ADDR = 1'b0; busA.DATA_IN = 32'h3FF; busA.READ = 2'b11;
    busB.WRITE = 1'b1; busB.BLOCK_ADDR = 1'b0; busB.DATA_IN = 32'h3FF; busB.READ = 2'b11;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("RST.A.EMPTY",    64'(busA.EMPTY),    64'h3);
    checkOutput("RST.A.FULL",     64'(busA.FULL),     64'h0);
    checkOutput("RST.A.STATUS",   64'(busA.STATUS),   64'h0);
    checkOutput("RST.A.DATA_VLD", 64'(busA.DATA_VLD), 64'h0);
    checkOutput("RST.A.DATA_OUT", 64'(busA.DATA_OUT), 64'h0);
    checkOutput("RST.B.EMPTY",    64'(busB.EMPTY),    64'h3);
    checkOutput("RST.B.STATUS",   64'(busB.STATUS),   64'h0);
    checkOutput("RST.B.DATA_VLD", 64'(busB.DATA_VLD), 64'h0);
    @(negedge clk);
    idle(1);
    rst = 1'b1;
    idle(2);

    $display("[TB] random traffic");
    for (int phase = 0; phase < 6; phase++) begin
      int wp;
      int rp;
      wp = (phase % 3 == 0) ? 85 : ((phase % 3 == 1) ? 50 : 15);
      rp = (phase % 3 == 0) ? 15 : ((phase % 3 == 1) ? 50 : 85);
      for (int c = 0; c < 250; c++) begin
        logic wr;
        logic addr;
        logic [FLOWS-1:0] rd;
        wr    = ($urandom_range(0, 99) < wp);
        addr  = (phase == 3) ? 1'b0 : 1'($urandom_range(0, 1));
        rd[0] = ($urandom_range(0, 99) < rp);
        rd[1] = ($urandom_range(0, 99) < rp);
        applyStimulus(wr, addr, $urandom, rd);
      end
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
